// File: rtl/llenado_pkg.sv
// Shared types and default timing constants for the bottle filling line.
// The state encodings are also shown on the operator LEDs, so they must not be renumbered.
package llenado_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_FILLING = 3'd2,
        ST_FULL    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_FAULT   = 3'd5
    } filler_state_t;

    localparam int unsigned SETTLE_TICKS_DEF   = 2;
    localparam int unsigned MAX_FILL_TICKS_DEF = 10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fsm_filler_control_if.sv
// Sensor, operator and actuator signals of the fill station, bundled as one port.
// The master side drives the sensors and reads the actuators; the slave side is the controller.
interface fsm_filler_control_if #(
    parameter int unsigned COUNT_W = 8
);
    logic               bottle_present;
    logic               level_full;
    logic               seal_done;
    logic               fault_clr;
    logic               valve;
    logic               lleno_flag;
    logic               fault;
    logic [2:0]         state_indicator;
    logic [COUNT_W-1:0] bottle_count;

    modport master (
        output bottle_present, level_full, seal_done, fault_clr,
        input  valve, lleno_flag, fault, state_indicator, bottle_count
    );

    modport slave (
        input  bottle_present, level_full, seal_done, fault_clr,
        output valve, lleno_flag, fault, state_indicator, bottle_count
    );
endinterface

// File: rtl/tick_counter.sv
// Saturating tick counter with synchronous clear and enable; at_term flags count == term_val.
// The compare is made against the registered count, so at_term carries no path from clr or en.
module tick_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic         at_term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term = (cnt_q == term_val);

endmodule

// File: rtl/fsm_filler_control.sv
// Moore controller for the fill station: settle, fill until full or timeout, hold full until sealed.
// All outputs decode the state register only; bottle_count advances on the FILLING->FULL edge.
module fsm_filler_control
    import llenado_pkg::*;
#(
    parameter int unsigned SETTLE_TICKS   = SETTLE_TICKS_DEF,
    parameter int unsigned MAX_FILL_TICKS = MAX_FILL_TICKS_DEF,
    parameter int unsigned COUNT_W        = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    fsm_filler_control_if.slave bus
);

    localparam int unsigned TMR_W = $clog2(max_u(SETTLE_TICKS, MAX_FILL_TICKS) + 1);

    filler_state_t      state_q;
    filler_state_t      state_d;
    logic [COUNT_W-1:0] bottle_count_q;
    logic [COUNT_W-1:0] bottle_count_d;
    logic [TMR_W-1:0]   term_val;
    logic               tmr_done;
    logic               tmr_clr;

    // One timer serves both SETTLE and FILLING; only the terminal value changes.
    assign term_val = (state_q == ST_SETTLE) ? TMR_W'(SETTLE_TICKS - 1)
                                             : TMR_W'(MAX_FILL_TICKS - 1);
    assign tmr_clr  = (state_d != state_q);

    tick_counter #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .en       (1'b1),
        .term_val (term_val),
        .at_term  (tmr_done)
    );

    always_comb begin
        state_d        = state_q;
        bottle_count_d = bottle_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.bottle_present) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!bus.bottle_present) state_d = ST_IDLE;
                else if (tmr_done)       state_d = ST_FILLING;
            end
            ST_FILLING: begin
                // Full beats timeout when both land on the same cycle.
                if (!bus.bottle_present) begin
                    state_d = ST_FAULT;
                end else if (bus.level_full) begin
                    state_d        = ST_FULL;
                    bottle_count_d = bottle_count_q + COUNT_W'(1);
                end else if (tmr_done) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FULL: begin
                if (!bus.bottle_present) state_d = ST_FAULT;
                else if (bus.seal_done)  state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus.bottle_present) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (bus.fault_clr && !bus.bottle_present) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            bottle_count_q <= '0;
        end else begin
            state_q        <= state_d;
            bottle_count_q <= bottle_count_d;
        end
    end

    assign bus.valve           = (state_q == ST_FILLING);
    assign bus.lleno_flag      = (state_q == ST_FULL);
    assign bus.fault           = (state_q == ST_FAULT);
    assign bus.state_indicator = state_q;
    assign bus.bottle_count    = bottle_count_q;

endmodule

// File: tb/tb_fsm_filler_control.sv
// Directed bench for fsm_filler_control: default-width unit for the flow and faults,
// a 2-bit counter unit for count wrap.
module tb_fsm_filler_control;

    logic clk = 1'b0;
    logic rst_n;
    logic bp, lf, sd, fc;
    logic sel;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fsm_filler_control_if #(.COUNT_W(8)) bus0 ();
    fsm_filler_control_if #(.COUNT_W(2)) bus1 ();

    assign bus0.bottle_present = bp & ~sel;
    assign bus0.level_full     = lf & ~sel;
    assign bus0.seal_done      = sd & ~sel;
    assign bus0.fault_clr      = fc & ~sel;
    assign bus1.bottle_present = bp & sel;
    assign bus1.level_full     = lf & sel;
    assign bus1.seal_done      = sd & sel;
    assign bus1.fault_clr      = fc & sel;

    fsm_filler_control #(
        .SETTLE_TICKS   (2),
        .MAX_FILL_TICKS (10),
        .COUNT_W        (8)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    fsm_filler_control #(
        .SETTLE_TICKS   (2),
        .MAX_FILL_TICKS (10),
        .COUNT_W        (2)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic [2:0] st;
    logic       vlv, lle, flt;
    logic [7:0] cnt;

    assign st  = sel ? bus1.state_indicator : bus0.state_indicator;
    assign vlv = sel ? bus1.valve           : bus0.valve;
    assign lle = sel ? bus1.lleno_flag      : bus0.lleno_flag;
    assign flt = sel ? bus1.fault           : bus0.fault;
    assign cnt = sel ? {6'd0, bus1.bottle_count} : bus0.bottle_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected state, valve, lleno_flag, fault in one call.
    task automatic chk_out(input string tag, input int s, input int v, input int l, input int f);
        chk({tag, ".state"}, 32'(st), s);
        chk({tag, ".valve"}, 32'(vlv), v);
        chk({tag, ".lleno"}, 32'(lle), l);
        chk({tag, ".fault"}, 32'(flt), f);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bp = 1'b0; lf = 1'b0; sd = 1'b0; fc = 1'b0; sel = 1'b0;
        #12;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.count", 32'(cnt), 0);
        rst_n = 1'b1;

        // seal_done outside FULL has no effect
        sd = 1'b1;
        tick(1);
        chk("stray_seal", 32'(st), 0);
        sd = 1'b0;

        // nominal fill
        bp = 1'b1;
        tick(1);
        chk_out("nom.settle0", 1, 0, 0, 0);
        tick(1);
        chk_out("nom.settle1", 1, 0, 0, 0);
        tick(1);
        chk_out("nom.fill0", 2, 1, 0, 0);
        for (int i = 1; i < 4; i++) begin
            tick(1);
            chk_out($sformatf("nom.fill%0d", i), 2, 1, 0, 0);
        end
        lf = 1'b1;
        tick(1);
        chk_out("nom.full", 3, 0, 1, 0);
        chk("nom.count", 32'(cnt), 1);
        lf = 1'b0;
        tick(2);
        chk_out("nom.full_hold", 3, 0, 1, 0);
        sd = 1'b1;
        tick(1);
        chk_out("nom.release", 4, 0, 0, 0);
        sd = 1'b0;
        tick(1);
        chk("nom.release_hold", 32'(st), 4);
        bp = 1'b0;
        tick(1);
        chk_out("nom.idle", 0, 0, 0, 0);

        // bounce 1,0,1,1 then pull the bottle mid-fill
        bp = 1'b1;
        tick(1);
        chk("bounce.settle", 32'(st), 1);
        bp = 1'b0;
        tick(1);
        chk("bounce.back_idle", 32'(st), 0);
        bp = 1'b1;
        tick(2);
        chk_out("bounce.settle_again", 1, 0, 0, 0);
        tick(1);
        chk_out("bounce.fill", 2, 1, 0, 0);
        bp = 1'b0;
        tick(1);
        chk_out("pull_fill.fault", 5, 0, 0, 1);
        bp = 1'b1;
        fc = 1'b1;
        tick(1);
        chk_out("clr_present.stay", 5, 0, 0, 1);
        bp = 1'b0;
        tick(1);
        chk_out("clr_absent.idle", 0, 0, 0, 0);
        fc = 1'b0;

        // timeout after exactly 10 FILLING cycles
        bp = 1'b1;
        tick(3);
        chk("tmo.fill0", 32'(st), 2);
        tick(9);
        chk_out("tmo.fill9", 2, 1, 0, 0);
        tick(1);
        chk_out("tmo.fault", 5, 0, 0, 1);
        chk("tmo.count", 32'(cnt), 1);
        bp = 1'b0;
        fc = 1'b1;
        tick(1);
        chk("tmo.clr", 32'(st), 0);
        fc = 1'b0;

        // level_full on the last FILLING cycle wins; then pull the bottle before sealing
        bp = 1'b1;
        tick(3);
        tick(9);
        lf = 1'b1;
        tick(1);
        chk_out("tie.full", 3, 0, 1, 0);
        chk("tie.count", 32'(cnt), 2);
        lf = 1'b0;
        bp = 1'b0;
        tick(1);
        chk_out("pull_full.fault", 5, 0, 0, 1);
        fc = 1'b1;
        tick(1);
        chk("pull_full.clr", 32'(st), 0);
        fc = 1'b0;

        // asynchronous reset during FILLING
        bp = 1'b1;
        tick(3);
        chk("arst.pre_valve", 32'(vlv), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst.outputs", 0, 0, 0, 0);
        chk("arst.count", 32'(cnt), 0);
        bp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // count wrap on the 2-bit unit
        sel = 1'b1;
        #1;
        chk("wrap.start", 32'(cnt), 0);
        for (int k = 0; k < 5; k++) begin
            bp = 1'b1;
            tick(3);
            lf = 1'b1;
            tick(1);
            chk($sformatf("wrap.count%0d", k), 32'(cnt), (k + 1) % 4);
            lf = 1'b0;
            sd = 1'b1;
            tick(1);
            sd = 1'b0;
            bp = 1'b0;
            tick(1);
            chk($sformatf("wrap.idle%0d", k), 32'(st), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fsm_filler_control.md
# fsm_filler_control

Moore state machine that controls bottle filling, directly upstream of the sealing stage. It confirms a bottle is stably present, opens the fill valve, and waits for the level sensor or a timeout. It then raises `lleno_flag` and holds it until the sealer reports completion. It runs on the same 1 Hz tick clock as the sealer, counts bottles filled, and latches faults until an operator clears them.

## Interface
- `SETTLE_TICKS`, default 2: consecutive cycles `bottle_present` must stay high before filling starts; must be ≥1.
- `MAX_FILL_TICKS`, default 10: maximum cycles in FILLING before a timeout fault; must be ≥1.
- `COUNT_W`, default 8: width of `bottle_count`.
- `clk`  in  1  system clock (1 Hz tick domain shared with the sealer).
- `rst_n`  in  1  asynchronous, active-low reset.
- `bottle_present`  in  1  bottle sensor at the fill station.
- `level_full`  in  1  liquid level sensor; high means the bottle is full.
- `seal_done`  in  1  completion pulse from the sealer (its `LED` output, high for 1 cycle).
- `fault_clr`  in  1  operator fault acknowledge.
- `valve`  out  1  fill valve open.
- `lleno_flag`  out  1  fill complete; drives the sealer's `lleno_flag`.
- `fault`  out  1  fault latched.
- `state_indicator`  out  3  current state encoding, for the LEDs.
- `bottle_count`  out  COUNT_W  number of bottles filled successfully.

## Operation
- States and encodings: IDLE=0, SETTLE=1, FILLING=2, FULL=3, RELEASE=4, FAULT=5. Encodings 6 and 7 are illegal and go to IDLE on the next cycle.
- Outputs are decoded from the state register only. There is no combinational path from inputs to outputs.
  - `valve` is high only in FILLING.
  - `lleno_flag` is high only in FULL.
  - `fault` is high only in FAULT.
  - `state_indicator` equals the state encoding.
- A single internal tick timer is cleared on every state change and increments while the state is unchanged.
- IDLE: when `bottle_present` is high, go to SETTLE.
- SETTLE:
  - If `bottle_present` is low, go to IDLE.
  - Otherwise, go to FILLING when the timer equals SETTLE_TICKS-1.
- FILLING, checked in priority order:
  1. `bottle_present` low → FAULT.
  2. `level_full` high → FULL, and `bottle_count` increments in the same cycle.
  3. Timer equals MAX_FILL_TICKS-1 → FAULT (timeout).
- FULL, checked in priority order:
  1. `bottle_present` low → FAULT, because the bottle left unsealed.
  2. `seal_done` high → RELEASE.
- RELEASE: when `bottle_present` is low, go to IDLE. This prevents refilling the same bottle.
- FAULT: when `fault_clr` is high and `bottle_present` is low, go to IDLE. If `fault_clr` arrives while a bottle is present, it is ignored and the FSM stays in FAULT.
- `bottle_count` wraps modulo 2^COUNT_W. It is never cleared except by reset.
- Timer width is $clog2(max(SETTLE_TICKS, MAX_FILL_TICKS)+1). The timer saturates and never wraps.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state=IDLE, timer=0, `bottle_count`=0;
  - `valve`=0, `lleno_flag`=0, `fault`=0, `state_indicator`=0.
- Reset mid-fill closes the valve immediately, without waiting for a clock edge.
- Bottle arrival to valve open: 1 cycle (IDLE→SETTLE) plus SETTLE_TICKS cycles. With defaults, `bottle_present` rising before edge 0 gives `valve`=1 after edge 2.
- `level_full` sampled high in FILLING: `valve` falls and `lleno_flag` rises on the next edge.
- Timeout: FILLING lasts at most MAX_FILL_TICKS cycles.
- If `level_full` is high on the same cycle the timer reaches MAX_FILL_TICKS-1, FULL wins.
- `lleno_flag` is held for at least 1 cycle and stays high until `seal_done` is sampled. The sealer therefore cannot miss it.
- A `seal_done` pulse outside FULL is ignored.

## Structure
- Package `llenado_pkg` holds:
  - `filler_state_t`, a 3-bit enum with the encodings above;
  - default constants for SETTLE_TICKS and MAX_FILL_TICKS.
- One sub-module, `tick_counter`: a parameterised saturating counter with synchronous clear, enable, and a terminal-compare output. It is reusable by the sealer stage.
- Use a two-process FSM: a registered state/timer/count process and a combinational next-state process.

## Test plan
- Nominal fill: `bottle_present`=1 held, `level_full` rises 4 cycles after the valve opens, and `seal_done` pulses 3 cycles into FULL. Required sequence: IDLE→SETTLE→FILLING→FULL→RELEASE; `valve` high 4 cycles; `bottle_count` goes 0→1. When the bottle is removed, the FSM returns to IDLE.
- Bounce: `bottle_present` pattern 1,0,1,1 → SETTLE returns to IDLE on the 0; `valve` opens only after the second consecutive settle period.
- Timeout: `level_full` never rises → FAULT after exactly 10 FILLING cycles; `valve`=0, `fault`=1, `bottle_count` unchanged.
- Removal faults:
  - bottle pulled in FILLING → FAULT;
  - bottle pulled in FULL before `seal_done` → FAULT;
  - `fault_clr` with bottle present → stays in FAULT;
  - `fault_clr` with bottle absent → IDLE.
- Wrap: with COUNT_W=2, 5 nominal cycles → `bottle_count` reads 1,2,3,0,1.
- Reset: assert `rst_n`=0 between clock edges during FILLING → `valve` drops immediately, all outputs return to 0, and state=IDLE.
